// File: rtl/regfile_pkg.sv
// Shared types and width helpers for the banked multi-port register file.
// Pending entries use fixed maximum field widths: WIDTH <= 64, row bits <= 16.
package regfile_pkg;

  localparam int unsigned PEND_ROW_W  = 16;
  localparam int unsigned PEND_DATA_W = 64;

  typedef enum logic [1:0] {
    SWEEP = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [PEND_ROW_W-1:0]  row;
    logic [PEND_DATA_W-1:0] data;
  } pend_t;

  // Index width for n items, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/regfile_bank_nr1w.sv
// One register bank: NR asynchronous read ports, one synchronous write port,
// no reset on the storage array.
module regfile_bank_nr1w
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ROWS  = 16,
  parameter int unsigned NR    = 4,
  localparam int unsigned RW   = idx_w(ROWS)
) (
  input  logic                      clk,
  input  logic [NR-1:0][RW-1:0]     ra_i,
  output logic [NR-1:0][WIDTH-1:0]  rd_o,
  input  logic                      we_i,
  input  logic [RW-1:0]             wa_i,
  input  logic [WIDTH-1:0]          wd_i
);

  logic [WIDTH-1:0] mem_q [ROWS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    for (int r = 0; r < NR; r++) begin
      rd_o[r] = mem_q[ra_i[r]];
    end
  end

endmodule

// File: rtl/banked_regfile_nrnw.sv
// Banked NR-read / NW-write register file: write arbitration, per-bank
// pending queues for bank conflicts, sweep/run/drain FSM and read muxes.
module banked_regfile_nrnw
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned NR        = 4,
  parameter int unsigned NW        = 2,
  parameter int unsigned NBANK     = 2,
  parameter bit          RST_SWEEP = 1'b1,
  parameter bit          ZERO_REG  = 1'b1,
  localparam int unsigned AW       = idx_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NR-1:0][AW-1:0]     ra_i,
  output logic [NR-1:0][WIDTH-1:0]  rd_o,
  input  logic [NW-1:0][AW-1:0]     wa_i,
  input  logic [NW-1:0][WIDTH-1:0]  wd_i,
  input  logic [NW-1:0]             we_i,
  output logic                      wready_o,
  output logic                      conflict_o,
  output logic                      init_done_o
);

  localparam int unsigned ROWS = DEPTH / NBANK;
  localparam int unsigned RW   = idx_w(ROWS);
  localparam int unsigned BIW  = idx_w(NBANK);
  localparam int unsigned QD   = (NW > 1) ? NW - 1 : 1;
  localparam int unsigned CW   = idx_w(QD + 1);

  function automatic logic [BIW-1:0] bank_of(input logic [AW-1:0] a);
    return BIW'(a % AW'(NBANK));
  endfunction

  function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
    return RW'(a / AW'(NBANK));
  endfunction

  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic              wready_q, wready_d;
  logic              init_done_q, init_done_d;
  pend_t             pq_q [NBANK][QD];
  pend_t             pq_d [NBANK][QD];
  logic [CW-1:0]     cnt_q [NBANK];
  logic [CW-1:0]     cnt_d [NBANK];

  logic [NW-1:0]             acc_s;
  logic                      conflict_s;
  logic                      any_left_s;
  logic [NBANK-1:0]          bwe_s;
  logic [RW-1:0]             bwa_s [NBANK];
  logic [WIDTH-1:0]          bwd_s [NBANK];
  logic [NR-1:0][RW-1:0]     rrow_s;
  logic [NR-1:0][WIDTH-1:0]  bank_rd_s [NBANK];

  // Accepted write ports: lower ports win same-address collisions, address 0 is discarded.
  always_comb begin
    acc_s = '0;
    for (int p = 0; p < NW; p++) begin
      acc_s[p] = we_i[p] & wready_q & ~(ZERO_REG & (wa_i[p] == '0));
      for (int q = 0; q < p; q++) begin
        acc_s[p] = acc_s[p] & ~(we_i[q] & (wa_i[q] == wa_i[p]));
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    wready_d    = wready_q;
    init_done_d = init_done_q;
    pq_d        = pq_q;
    cnt_d       = cnt_q;
    conflict_s  = 1'b0;
    any_left_s  = 1'b0;
    bwe_s       = '0;
    for (int b = 0; b < NBANK; b++) begin
      bwa_s[b] = '0;
      bwd_s[b] = '0;
    end
    case (state_q)
      SWEEP: begin
        if (RST_SWEEP) begin
          bwe_s = '1;
          for (int b = 0; b < NBANK; b++) begin
            bwa_s[b] = row_q;
          end
        end
        if (!RST_SWEEP || (row_q == RW'(ROWS - 1))) begin
          state_d     = RUN;
          row_d       = '0;
          wready_d    = 1'b1;
          init_done_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      RUN: begin
        // First accepted port per bank commits; later ones queue in port order.
        for (int p = 0; p < NW; p++) begin
          for (int b = 0; b < NBANK; b++) begin
            if (acc_s[p] && (bank_of(wa_i[p]) == BIW'(b))) begin
              if (!bwe_s[b]) begin
                bwe_s[b] = 1'b1;
                bwa_s[b] = row_of(wa_i[p]);
                bwd_s[b] = wd_i[p];
              end else begin
                for (int s = 0; s < QD; s++) begin
                  if (CW'(s) == cnt_d[b]) begin
                    pq_d[b][s].row  = PEND_ROW_W'(row_of(wa_i[p]));
                    pq_d[b][s].data = PEND_DATA_W'(wd_i[p]);
                  end
                end
                cnt_d[b]   = cnt_d[b] + CW'(1);
                conflict_s = 1'b1;
              end
            end
          end
        end
        for (int b = 0; b < NBANK; b++) begin
          any_left_s = any_left_s | (cnt_d[b] != '0);
        end
        if (any_left_s) begin
          state_d  = DRAIN;
          wready_d = 1'b0;
        end
      end
      DRAIN: begin
        for (int b = 0; b < NBANK; b++) begin
          if (cnt_q[b] != '0) begin
            bwe_s[b] = 1'b1;
            bwa_s[b] = pq_q[b][0].row[RW-1:0];
            bwd_s[b] = pq_q[b][0].data[WIDTH-1:0];
            for (int s = 0; s < QD - 1; s++) begin
              pq_d[b][s] = pq_q[b][s + 1];
            end
            cnt_d[b] = cnt_q[b] - CW'(1);
          end
          any_left_s = any_left_s | (cnt_d[b] != '0);
        end
        if (!any_left_s) begin
          state_d  = RUN;
          wready_d = 1'b1;
        end
      end
      default: begin
        state_d  = SWEEP;
        row_d    = '0;
        wready_d = 1'b0;
      end
    endcase
    // Reset abandons any storage update in flight this edge.
    if (!rst_n) begin
      bwe_s = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SWEEP;
      row_q       <= '0;
      wready_q    <= 1'b0;
      init_done_q <= 1'b0;
      for (int b = 0; b < NBANK; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      wready_q    <= wready_d;
      init_done_q <= init_done_d;
      pq_q        <= pq_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NR; r++) begin
      rrow_s[r] = row_of(ra_i[r]);
    end
  end

  for (genvar gb = 0; gb < NBANK; gb++) begin : g_bank
    regfile_bank_nr1w #(
      .WIDTH (WIDTH),
      .ROWS  (ROWS),
      .NR    (NR)
    ) u_bank (
      .clk   (clk),
      .ra_i  (rrow_s),
      .rd_o  (bank_rd_s[gb]),
      .we_i  (bwe_s[gb]),
      .wa_i  (bwa_s[gb]),
      .wd_i  (bwd_s[gb])
    );
  end

  // Read priority: zero register, then newest pending entry, then storage.
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      rd_o[r] = '0;
      for (int b = 0; b < NBANK; b++) begin
        if (bank_of(ra_i[r]) == BIW'(b)) begin
          rd_o[r] = bank_rd_s[b][r];
          for (int s = 0; s < QD; s++) begin
            if ((CW'(s) < cnt_q[b]) && (pq_q[b][s].row == PEND_ROW_W'(rrow_s[r]))) begin
              rd_o[r] = pq_q[b][s].data[WIDTH-1:0];
            end
          end
        end
      end
      if (ZERO_REG && (ra_i[r] == '0)) begin
        rd_o[r] = '0;
      end
    end
  end

  assign wready_o    = wready_q;
  assign conflict_o  = conflict_s;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_banked_regfile_nrnw.sv
// Scoreboard bench for banked_regfile_nrnw (default parameters): stimulus
// pushes per-cycle expectations, a negedge monitor pops and compares them.
module tb_banked_regfile_nrnw;

  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_CF = 2;
  localparam int K_IN = 3;

  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0][4:0]  ra;
  logic [3:0][31:0] rd;
  logic [1:0][4:0]  wa;
  logic [1:0][31:0] wd;
  logic [1:0]       we;
  logic             wready, conflict, init_done;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] act;
  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  banked_regfile_nrnw dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ra_i        (ra),
    .rd_o        (rd),
    .wa_i        (wa),
    .wd_i        (wd),
    .we_i        (we),
    .wready_o    (wready),
    .conflict_o  (conflict),
    .init_done_o (init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD:    act = rd[e.port];
        K_WR:    act = {31'd0, wready};
        K_CF:    act = {31'd0, conflict};
        K_IN:    act = {31'd0, init_done};
        default: act = 32'hxxxx_xxxx;
      endcase
      tests_run++;
      if (act !== e.val) begin
        tests_failed++;
        $display("FAIL %s (cycle %0d): got %0h expected %0h", e.name, e.cyc, act, e.val);
      end
    end
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
    we = '0;
    ra = '0;
  endtask

  task automatic exp_push(input int k, input int p, input logic [31:0] v, input string nm);
    exp_t x;
    x.cyc = cyc; x.kind = k; x.port = p; x.val = v; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic chk_rd(input int p, input int a, input logic [31:0] v);
    ra[p] = a[4:0];
    exp_push(K_RD, p, v, $sformatf("rd%0d_addr%0d", p, a));
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    we[p] = 1'b1;
    wa[p] = a[4:0];
    wd[p] = d;
  endtask

  // Called in the first rst_n=1 cycle: 16 sweep cycles, then RUN, then all-zero reads.
  task automatic sweep_and_zero_check(input string tag);
    for (int i = 0; i < 17; i++) begin
      if (i != 0) cyc_start();
      exp_push(K_IN, 0, (i == 16) ? 32'd1 : 32'd0, $sformatf("%s_init_c%0d", tag, i));
      exp_push(K_WR, 0, (i == 16) ? 32'd1 : 32'd0, $sformatf("%s_wready_c%0d", tag, i));
    end
    for (int g = 0; g < 8; g++) begin
      cyc_start();
      for (int p = 0; p < 4; p++) chk_rd(p, g * 4 + p, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; we = '0; wa = '0; wd = '0; ra = '0;
    repeat (3) cyc_start();
    exp_push(K_WR, 0, 32'd0, "rst_wready");
    exp_push(K_IN, 0, 32'd0, "rst_init");
    exp_push(K_CF, 0, 32'd0, "rst_conflict");

    cyc_start();
    rst_n = 1'b1;
    sweep_and_zero_check("sweep");

    // Dual write to different banks; no same-cycle forwarding.
    cyc_start();
    wr(0, 3, 32'hAA); wr(1, 4, 32'hBB);
    chk_rd(0, 3, 32'd0);
    exp_push(K_CF, 0, 32'd0, "nc_conflict");
    exp_push(K_WR, 0, 32'd1, "nc_wready");
    cyc_start();
    chk_rd(0, 3, 32'hAA); chk_rd(1, 4, 32'hBB);
    exp_push(K_WR, 0, 32'd1, "nc_wready_next");

    // Bank conflict: addr 6 queues, one drain cycle, forwarded meanwhile.
    cyc_start();
    wr(0, 2, 32'h11); wr(1, 6, 32'h22);
    exp_push(K_CF, 0, 32'd1, "bc_conflict");
    exp_push(K_WR, 0, 32'd1, "bc_wready");
    chk_rd(0, 6, 32'd0);
    cyc_start();
    wr(0, 7, 32'h77);
    exp_push(K_WR, 0, 32'd0, "bc_drain_wready");
    exp_push(K_CF, 0, 32'd0, "bc_drain_conflict");
    chk_rd(0, 6, 32'h22); chk_rd(1, 2, 32'h11); chk_rd(2, 7, 32'd0);
    cyc_start();
    exp_push(K_WR, 0, 32'd1, "bc_run_wready");
    chk_rd(0, 6, 32'h22); chk_rd(1, 7, 32'd0);

    // Same address on both ports: port 0 wins, no stall.
    cyc_start();
    wr(0, 5, 32'h1); wr(1, 5, 32'h2);
    exp_push(K_CF, 0, 32'd0, "sa_conflict");
    cyc_start();
    chk_rd(0, 5, 32'h1);
    exp_push(K_WR, 0, 32'd1, "sa_wready");

    // Zero register ignores writes.
    cyc_start();
    wr(0, 0, 32'hFF);
    cyc_start();
    chk_rd(0, 0, 32'd0);
    exp_push(K_WR, 0, 32'd1, "zr_wready");

    // Reset during DRAIN discards the queue and re-sweeps.
    cyc_start();
    wr(0, 10, 32'h33); wr(1, 12, 32'h44);
    exp_push(K_CF, 0, 32'd1, "rd_conflict");
    cyc_start();
    rst_n = 1'b0;
    exp_push(K_WR, 0, 32'd0, "rd_drain_wready");
    exp_push(K_CF, 0, 32'd0, "rd_drain_conflict");
    chk_rd(0, 12, 32'h44); chk_rd(1, 10, 32'h33);
    cyc_start();
    rst_n = 1'b1;
    sweep_and_zero_check("resweep");

    repeat (2) cyc_start();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
